// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, low time and period of an asynchronous PWM line
// in clk cycles, and flags a line that has stopped toggling.
module pwm_capture #(
    parameter int unsigned      CNT_W       = 24,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0] TIMEOUT     = 24'd8000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] hi_time,
    output logic [CNT_W-1:0] lo_time,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam int unsigned NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    state_t           state, state_nx;
    logic [NSYNC-1:0] sync;
    logic             s, s_d;
    logic             rise, fall, toggle, at_limit;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_acc;
    logic             capture, publish;

    assign s        = sync[NSYNC-1];
    assign rise     = s & ~s_d;
    assign fall     = ~s & s_d;
    assign toggle   = rise | fall;
    assign at_limit = (cnt == TIMEOUT);

    // IDLE ignores a rise because the high phase seen after reset may be partial.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        publish  = 1'b0;
        unique case (state)
            IDLE: if (fall) state_nx = ARM;
            ARM:  if (rise) state_nx = HIGH;
            HIGH: begin
                if (fall) begin
                    state_nx = LOW;
                    capture  = 1'b1;
                end else if (at_limit) begin
                    state_nx = IDLE;
                end
            end
            LOW: begin
                if (rise) begin
                    state_nx = HIGH;
                    publish  = 1'b1;
                end else if (at_limit) begin
                    state_nx = ARM;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync       <= '0;
            s_d        <= 1'b0;
            cnt        <= '0;
            state      <= IDLE;
            hi_acc     <= '0;
            hi_time    <= '0;
            lo_time    <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
        end else begin
            sync  <= {sync[NSYNC-2:0], sig_in};
            s_d   <= s;
            state <= state_nx;

            if (toggle)
                cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            else if (!at_limit)
                cnt <= cnt + 1'b1;

            if (capture)
                hi_acc <= cnt;

            meas_valid <= publish;
            if (publish) begin
                hi_time <= hi_acc;
                lo_time <= cnt;
                period  <= {1'b0, hi_acc} + {1'b0, cnt};
            end

            // An edge in the same cycle as the limit wins; flags report the level held.
            if (toggle) begin
                stuck_high <= 1'b0;
                stuck_low  <= 1'b0;
            end else if (at_limit) begin
                if (s)
                    stuck_high <= 1'b1;
                else
                    stuck_low  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives run-length waveforms into pwm_capture and checks every cycle
// against expectations derived from the run lengths.
module tb_pwm_capture;

    localparam int unsigned CNT_W = 24;
    localparam int unsigned W1    = CNT_W + 1;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned TMO   = 100;
    // drive at negedge n -> registered result visible at negedge n + LAT
    localparam int unsigned LAT   = SYNC + 1;

    logic             clk    = 1'b0;
    logic             rst    = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] hi_time, lo_time;
    logic [CNT_W:0]   period;
    logic             meas_valid, stuck_high, stuck_low;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (24'd100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .hi_time    (hi_time),
        .lo_time    (lo_time),
        .period     (period),
        .meas_valid (meas_valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low)
    );

    task automatic chk(input string tag, input logic [W1-1:0] obs, input logic [W1-1:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, want, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".hi_time"},    W1'(hi_time),    '0);
        chk({tag, ".lo_time"},    W1'(lo_time),    '0);
        chk({tag, ".period"},     period,          '0);
        chk({tag, ".meas_valid"}, W1'(meas_valid), '0);
        chk({tag, ".stuck_high"}, W1'(stuck_high), '0);
        chk({tag, ".stuck_low"},  W1'(stuck_low),  '0);
    endtask

    // Called at a negedge; releases reset at a negedge.
    task automatic reset_dut();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
    endtask

    // rl: alternating run lengths of the input, first run high, preceded by the
    // low level held since reset.  Measurement rule: the rise ending low run i+1
    // reports (rl[i], rl[i+1]) when high run i began after a fall (i >= 2) and
    // neither run exceeded TMO.  A run longer than TMO raises its level's flag
    // TMO cycles into the run until the next edge.
    task automatic play(input int unsigned rl[$]);
        int unsigned st[$];
        int unsigned total;
        bit          w[];
        bit          e_mv[], e_sh[], e_sl[];
        int unsigned e_hi[], e_lo[];
        total = 0;
        foreach (rl[i]) begin
            st.push_back(total);
            total += rl[i];
        end
        w    = new[total];
        e_mv = new[total];
        e_sh = new[total];
        e_sl = new[total];
        e_hi = new[total];
        e_lo = new[total];
        foreach (rl[i])
            for (int unsigned k = 0; k < rl[i]; k++)
                w[st[i] + k] = (i % 2 == 0);
        for (int i = 2; i + 2 < rl.size(); i += 2) begin
            int unsigned at;
            at = st[i+2] + LAT;
            if (rl[i] <= TMO && rl[i+1] <= TMO && at < total) begin
                e_mv[at] = 1'b1;
                for (int unsigned m = at; m < total; m++) begin
                    e_hi[m] = rl[i];
                    e_lo[m] = rl[i+1];
                end
            end
        end
        foreach (rl[i])
            if (rl[i] > TMO)
                for (int unsigned m = st[i] + LAT + TMO; m < st[i] + rl[i] + LAT && m < total; m++)
                    if (i % 2 == 0) e_sh[m] = 1'b1;
                    else            e_sl[m] = 1'b1;
        for (int unsigned m = 0; m < total; m++) begin
            chk("meas_valid", W1'(meas_valid), W1'(e_mv[m]));
            chk("hi_time",    W1'(hi_time),    W1'(e_hi[m]));
            chk("lo_time",    W1'(lo_time),    W1'(e_lo[m]));
            chk("period",     period,          W1'(e_hi[m] + e_lo[m]));
            chk("stuck_high", W1'(stuck_high), W1'(e_sh[m]));
            chk("stuck_low",  W1'(stuck_low),  W1'(e_sl[m]));
            sig_in = w[m];
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned seg[$];

        @(negedge clk);
        reset_dut();

        // 5/7 periods, stuck high, stuck low, then resume through the ARM path
        seg = {};
        repeat (5) begin seg.push_back(5); seg.push_back(7); end
        seg.push_back(150);
        seg.push_back(150);
        repeat (4) begin seg.push_back(5); seg.push_back(7); end
        seg.push_back(10);
        play(seg);
        reset_dut();

        // duty sweep at period 21, then phases exactly at the timeout limit
        seg = {};
        for (int unsigned h = 1; h <= 20; h++) begin
            seg.push_back(h);
            seg.push_back(21 - h);
        end
        seg.push_back(100); seg.push_back(100);
        seg.push_back(5);   seg.push_back(7);
        seg.push_back(10);
        play(seg);
        reset_dut();

        // random phase lengths
        seg = {};
        repeat (20) begin
            seg.push_back($urandom_range(1, 40));
            seg.push_back($urandom_range(1, 40));
        end
        seg.push_back(10);
        play(seg);
        reset_dut();

        // reset asserted mid high phase, released with the line still high
        seg = {5, 7, 5, 7, 5, 7, 3};
        play(seg);
        #2 rst = 1'b0;
        #1 chk_zero("async_reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        seg = {4, 7, 5, 7, 5, 7, 10};
        play(seg);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
